// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by a shared OVERSAMPLE x baud strobe.
// The start bit is validated at mid-bit, 8 data bits are shifted in LSB first,
// and the stop bit is checked. Each byte is presented with a one-clk rx_valid
// pulse and a frame_err flag. A stop bit sampled low parks the receiver in
// BREAK until the line returns high.
// Optional build macro UART_RX_MAJORITY_EN: each sample point takes the 2-of-3
// majority of line over the current and two preceding strobes.
module uart_rx #(
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stb_os,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t                 state;
   logic [TW-1:0]          tick_cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift_reg;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line;
   logic                   sample_bit;

   // Synchronise the asynchronous serial line into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
      end
   end

   assign line = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;

   // Keep the line value from the two previous strobes for the majority vote
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '1;
      end else if (stb_os) begin
         hist_q <= {hist_q[0], line};
      end
   end

   assign sample_bit = (line & hist_q[0]) | (line & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign sample_bit = line;
`endif

   // Receive FSM; advances only on strobes, rx_valid is a plain one-clk pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         data_out  <= '0;
         rx_valid  <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (stb_os) begin
            case (state)
               IDLE: begin
                  // edge detection deliberately uses the raw line, not the vote
                  if (!line) begin
                     state    <= START;
                     tick_cnt <= '0;
                     rx_busy  <= 1'b1;
                  end
               end
               START: begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     if (!sample_bit) begin
                        state   <= DATA;
                        bit_idx <= '0;
                     end else begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_cnt == TICK_LAST) begin
                     shift_reg[bit_idx] <= sample_bit;
                     tick_cnt           <= '0;
                     if (bit_idx == 3'd7) begin
                        state <= STOP;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               STOP: begin
                  // outputs register on the sampling strobe so they appear on the following clk
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt  <= '0;
                     data_out  <= shift_reg;
                     rx_valid  <= 1'b1;
                     frame_err <= ~sample_bit;
                     if (sample_bit) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                     end else begin
                        state <= BREAK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               BREAK: begin
                  if (line) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
